// File: rtl/cpu_reg_responder.sv
// cpu_reg_responder: responder end of the CPU management bus.
// Serves Intel-style (Rd/Wr/Rdy) and Motorola-style (DS/RW/Dtack) cycles
// against a per-VPI {FWD, VPI} cell-config table. The same table is also
// read every cycle through a registered lookup port used by the cell path.
//
// Handshake: the initiator holds Sel low with its strobe active until it
// sees the acknowledge, then releases. The responder acknowledges exactly
// once per accepted cycle and drops the acknowledge on the first edge that
// samples the release. A strobe released before the acknowledge aborts the
// cycle with no table write and counts as an illegal cycle.
module cpu_reg_responder #(
   parameter int  NUM_TX      = 4,
   parameter int  DEPTH       = 256,
   parameter int  WAIT_CYCLES = 1,
   localparam int DATA_W      = NUM_TX + 12
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              BusMode,
   input  logic [23:0]       Addr,
   input  logic              Sel,
   input  logic [DATA_W-1:0] DataIn,
   output logic [DATA_W-1:0] DataOut,
   input  logic              Rd_DS,
   input  logic              Wr_RW,
   output logic              Rdy_Dtack,
   input  logic [7:0]        lu_vpi,
   output logic [DATA_W-1:0] lu_data,
   output logic [7:0]        err_cnt
);

   localparam int IDX_W = $clog2(DEPTH);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_ACK  = 2'd2
   } state_t;

   state_t state_q, state_d;

   // Latched cycle context
   logic              mode_q;
   logic              dir_q;      // 1 = read, 0 = write
   logic [23:0]       addr_q;
   logic [DATA_W-1:0] data_q;
   logic [3:0]        wcnt_q;
   logic              ack_q;

   // Control strobes from the next-state logic
   logic go;
   logic start_rd;
   logic do_dec;
   logic do_commit;
   logic ack_clr;
   logic err_inc;

   logic              mode;
   logic              hold;
   logic              in_range;
   logic [IDX_W-1:0]  idx;
   logic [IDX_W-1:0]  lu_idx;
   logic              lu_ok;

   logic [DATA_W-1:0] cfg_mem [DEPTH];

   // Acknowledge polarity follows the live bus mode only while idle
   assign mode      = (state_q == S_IDLE) ? BusMode : mode_q;
   assign Rdy_Dtack = mode ? ack_q : ~ack_q;

   // The active cycle continues while selected and its own strobe stays low
   assign hold = ~Sel & (mode_q ? (dir_q ? ~Rd_DS : ~Wr_RW) : ~Rd_DS);

   assign in_range = (addr_q < 24'(DEPTH));
   assign idx      = addr_q[IDX_W-1:0];
   assign lu_idx   = IDX_W'(lu_vpi);

   generate
      if (DEPTH >= 256) begin : g_lu_full
         assign lu_ok = 1'b1;
      end else begin : g_lu_part
         assign lu_ok = (lu_vpi < 8'(DEPTH));
      end
   endgenerate

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   // Next-state decode and control strobes
   always_comb begin
      state_d   = state_q;
      go        = 1'b0;
      start_rd  = BusMode ? ~Rd_DS : Wr_RW;
      do_dec    = 1'b0;
      do_commit = 1'b0;
      ack_clr   = 1'b0;
      err_inc   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (!Sel) begin
               if (BusMode) begin
                  if (!Rd_DS && !Wr_RW) begin
                     err_inc = 1'b1;
                  end else if (!Rd_DS || !Wr_RW) begin
                     go      = 1'b1;
                     state_d = S_WAIT;
                  end
               end else if (!Rd_DS) begin
                  go      = 1'b1;
                  state_d = S_WAIT;
               end
            end
         end
         S_WAIT: begin
            if (!hold) begin
               err_inc = 1'b1;
               state_d = S_IDLE;
            end else if (wcnt_q == 4'd0) begin
               do_commit = 1'b1;
               state_d   = S_ACK;
            end else begin
               do_dec = 1'b1;
            end
         end
         S_ACK: begin
            if (!hold) begin
               ack_clr = 1'b1;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Cycle context, wait counter, acknowledge and error counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mode_q  <= 1'b0;
         dir_q   <= 1'b0;
         addr_q  <= '0;
         data_q  <= '0;
         wcnt_q  <= '0;
         ack_q   <= 1'b0;
         err_cnt <= '0;
      end else begin
         if (go) begin
            mode_q <= BusMode;
            dir_q  <= start_rd;
            addr_q <= Addr;
            data_q <= DataIn;
            wcnt_q <= 4'(WAIT_CYCLES);
         end else if (do_dec) begin
            wcnt_q <= wcnt_q - 4'd1;
         end
         if (do_commit)    ack_q <= 1'b1;
         else if (ack_clr) ack_q <= 1'b0;
         if (err_inc && (err_cnt != 8'hFF)) err_cnt <= err_cnt + 8'd1;
      end
   end

   // Table storage, bus read data and registered lookup port
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) cfg_mem[i] <= '0;
         DataOut <= '0;
         lu_data <= '0;
      end else begin
         if (do_commit) begin
            if (dir_q)         DataOut      <= in_range ? cfg_mem[idx] : '0;
            else if (in_range) cfg_mem[idx] <= data_q;
         end
         lu_data <= lu_ok ? cfg_mem[lu_idx] : '0;
      end
   end

endmodule
